// File: rtl/spi_req_scheduler.sv
// spi_req_scheduler
//
// Round-robin scheduler that shares one SPI master between NREQ requesters.
// A pending request is granted in IDLE, its word is presented on spi_din with
// spi_newd held high until the master's chip-select (synchronised) shows the
// transfer started. Completion (cs back high) produces a one-cycle ack to the
// grantee; a start that never happens within TIMEOUT cycles produces a
// one-cycle err instead. Each ack/err is followed by GAP idle cycles.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   DW       data word width, matches the master's din
//   TIMEOUT  cycles to wait in ISSUE for cs to go low before aborting
//   GAP      idle cycles after every ack/err before the next grant (>= 1)
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   req       per-requester request level
//   wdata     requester i word at [i*DW +: DW]
//   ack       one-cycle pulse, granted transfer completed
//   err       one-cycle pulse, granted transfer aborted on start timeout
//   busy      high whenever the scheduler is not idle
//   grant_id  index of current or last grantee
//   spi_newd  new-data strobe to the master
//   spi_din   word to the master, holds the last granted word
//   spi_cs    master chip-select (active low, asynchronous to clk)

module spi_req_scheduler #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 12,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned GAP     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      wdata,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         err,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    spi_newd,
    output logic [DW-1:0]           spi_din,
    input  logic                    spi_cs
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [IW-1:0] LastId    = IW'(NREQ - 1);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GapLast   = GW'(GAP - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StActive,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic            spi_newd_q, spi_newd_d;
    logic [DW-1:0]   spi_din_q, spi_din_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] err_q, err_d;

    // Two-flop synchroniser; idle level of chip-select is high.
    logic cs_meta_q;
    logic cs_s_q;

    logic            pick_valid;
    logic [IW-1:0]   pick_id;
    logic [IW-1:0]   next_ptr;

    // ------------------------------------------------------------------
    // Round-robin pick: first set request at or above rr_ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pick_valid && req[(32'(rr_ptr_q) + i) % NREQ]) begin
                pick_valid = 1'b1;
                pick_id    = IW'((32'(rr_ptr_q) + i) % NREQ);
            end
        end
    end

    // Pointer moves just past the grantee once its transfer finishes.
    assign next_ptr = (grant_id_q == LastId) ? '0 : grant_id_q + 1'b1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        spi_newd_d = spi_newd_q;
        spi_din_d  = spi_din_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        timer_d    = timer_q;
        gap_cnt_d  = gap_cnt_q;
        ack_d      = '0;
        err_d      = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    spi_din_d  = wdata[pick_id*DW +: DW];
                    grant_id_d = pick_id;
                    spi_newd_d = 1'b1;
                    timer_d    = '0;
                    state_d    = StIssue;
                end
            end

            StIssue: begin
                if (!cs_s_q) begin
                    spi_newd_d = 1'b0;
                    state_d    = StActive;
                end else if (timer_q == TimerLast) begin
                    spi_newd_d          = 1'b0;
                    err_d[grant_id_q]   = 1'b1;
                    rr_ptr_d            = next_ptr;
                    gap_cnt_d           = '0;
                    state_d             = StGap;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            // No timeout here: once started, the master always finishes.
            StActive: begin
                if (cs_s_q) begin
                    ack_d[grant_id_q] = 1'b1;
                    rr_ptr_d          = next_ptr;
                    gap_cnt_d         = '0;
                    state_d           = StGap;
                end
            end

            // Requests are not looked at here; arbitration only in IDLE.
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            spi_newd_q <= 1'b0;
            spi_din_q  <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            timer_q    <= '0;
            gap_cnt_q  <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            cs_meta_q  <= 1'b1;
            cs_s_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            spi_newd_q <= spi_newd_d;
            spi_din_q  <= spi_din_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            timer_q    <= timer_d;
            gap_cnt_q  <= gap_cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            cs_meta_q  <= spi_cs;
            cs_s_q     <= cs_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ack      = ack_q;
    assign err      = err_q;
    assign busy     = (state_q != StIdle);
    assign grant_id = grant_id_q;
    assign spi_newd = spi_newd_q;
    assign spi_din  = spi_din_q;

    // ack and err together are at most one-hot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0({ack_q, err_q}));
        end
    end

endmodule

// File: tb/tb_spi_req_scheduler.sv
module tb_spi_req_scheduler;

    localparam int NREQ    = 4;
    localparam int DW      = 12;
    localparam int TIMEOUT = 64;
    localparam int GAP     = 4;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      err;
    logic                 busy;
    logic [1:0]           grant_id;
    logic                 spi_newd;
    logic [DW-1:0]        spi_din;
    logic                 spi_cs;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    spi_req_scheduler #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .grant_id (grant_id),
        .spi_newd (spi_newd),
        .spi_din  (spi_din),
        .spi_cs   (spi_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        spi_cs = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Poll for spi_newd with a bound; returns cycle stamp of observation.
    task automatic wait_grant(output int gcyc);
        bit ok;
        ok   = 1'b0;
        gcyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (spi_newd === 1'b1) begin
                ok   = 1'b1;
                gcyc = cyc;
                break;
            end
        end
        check_eq("grant_wait", 32'(ok), 32'd1);
    endtask

    // Master model for one transfer, called right after a grant is seen.
    task automatic serve(input int lead, input int hold, input logic [NREQ-1:0] drop,
                         output logic [NREQ-1:0] acks, output logic [NREQ-1:0] errs,
                         output int acyc);
        bit ok;
        repeat (lead) @(negedge clk);
        spi_cs = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (spi_newd === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("newd_drop", 32'(ok), 32'd1);
        req = req & ~drop;
        repeat (hold) @(negedge clk);
        spi_cs = 1'b1;
        acks = '0;
        errs = '0;
        acyc = 0;
        ok   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((ack | err) !== '0) begin
                acks = ack;
                errs = err;
                acyc = cyc;
                ok   = 1'b1;
                break;
            end
        end
        check_eq("done_wait", 32'(ok), 32'd1);
        @(negedge clk);
        check_eq("pulse_width", 32'({ack, err}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] a, e, acc;
        int gcyc, acyc, last_ack, cnt;
        int order [5];
        order = '{0, 1, 2, 3, 0};

        req    = '0;
        wdata  = '0;
        spi_cs = 1'b1;
        rst    = 1'b1;
        reset_dut();

        // Reset state
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_newd", 32'(spi_newd), 32'd0);
        check_eq("rst_din", 32'(spi_din), 32'd0);
        check_eq("rst_gid", 32'(grant_id), 32'd0);
        check_eq("rst_ackerr", 32'({ack, err}), 32'd0);

        // 1: single request, exact cycle timing
        wdata[1*DW +: DW] = 12'hA5C;
        req = 4'b0010;
        @(negedge clk);
        check_eq("t1_newd", 32'(spi_newd), 32'd1);
        check_eq("t1_din", 32'(spi_din), 32'hA5C);
        check_eq("t1_gid", 32'(grant_id), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd1);
        repeat (29) @(negedge clk);
        spi_cs = 1'b0;
        @(negedge clk);
        check_eq("t1_newd_cs1", 32'(spi_newd), 32'd1);
        @(negedge clk);
        check_eq("t1_newd_cs2", 32'(spi_newd), 32'd1);
        @(negedge clk);
        check_eq("t1_newd_cs3", 32'(spi_newd), 32'd0);
        repeat (297) @(negedge clk);
        spi_cs = 1'b1;
        @(negedge clk);
        check_eq("t1_ack_b1", 32'(ack), 32'd0);
        @(negedge clk);
        check_eq("t1_ack_b2", 32'(ack), 32'd0);
        @(negedge clk);
        check_eq("t1_ack", 32'(ack), 32'b0010);
        check_eq("t1_err", 32'(err), 32'd0);
        req = '0;
        @(negedge clk);
        check_eq("t1_ack_once", 32'(ack), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("t1_busy_gap", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        check_eq("t1_busy_low", 32'(busy), 32'd0);
        check_eq("t1_din_hold", 32'(spi_din), 32'hA5C);

        // 2: all four continuously requesting
        reset_dut();
        for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = 12'(12'h111 * (i + 1));
        req = 4'b1111;
        last_ack = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(gcyc);
            check_eq("t2_gid", 32'(grant_id), 32'(order[k]));
            check_eq("t2_din", 32'(spi_din), 32'(12'h111 * (order[k] + 1)));
            if (k > 0) check_eq("t2_spacing", 32'((gcyc - last_ack) >= GAP + 1), 32'd1);
            serve(3, 5, 4'b0000, a, e, acyc);
            check_eq("t2_ack", 32'(a), 32'(1 << order[k]));
            check_eq("t2_err", 32'(e), 32'd0);
            last_ack = acyc;
        end
        req = '0;

        // 3: start timeout, then rr_ptr must sit past requester 2
        wdata[2*DW +: DW] = 12'h3C3;
        req = 4'b0100;
        wait_grant(gcyc);
        check_eq("t3_gid", 32'(grant_id), 32'd2);
        cnt = 1;
        acc = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = acc | ack;
            if (spi_newd !== 1'b1) break;
            cnt++;
        end
        check_eq("t3_newd_len", 32'(cnt), 32'(TIMEOUT));
        check_eq("t3_err", 32'(err), 32'b0100);
        check_eq("t3_noack", 32'(acc | ack), 32'd0);
        @(negedge clk);
        check_eq("t3_err_once", 32'(err), 32'd0);
        req = 4'b1100;
        wait_grant(gcyc);
        check_eq("t3_next_gid", 32'(grant_id), 32'd3);
        serve(2, 4, 4'b1000, a, e, acyc);
        check_eq("t3_ack3", 32'(a), 32'b1000);
        wait_grant(gcyc);
        check_eq("t3_then_gid", 32'(grant_id), 32'd2);
        serve(2, 4, 4'b0100, a, e, acyc);
        check_eq("t3_ack2", 32'(a), 32'b0100);

        // 4: wdata change after grant is ignored
        reset_dut();
        wdata[0*DW +: DW] = 12'h0F0;
        req = 4'b0001;
        wait_grant(gcyc);
        check_eq("t4_din", 32'(spi_din), 32'h0F0);
        @(negedge clk);
        wdata[0*DW +: DW] = 12'hFFF;
        serve(2, 6, 4'b0000, a, e, acyc);
        check_eq("t4_ack", 32'(a), 32'b0001);
        check_eq("t4_din_hold", 32'(spi_din), 32'h0F0);
        req = '0;

        // 5: reset while ACTIVE
        req = 4'b0100;
        wait_grant(gcyc);
        check_eq("t5_gid", 32'(grant_id), 32'd2);
        repeat (2) @(negedge clk);
        spi_cs = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t5_active_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst    = 1'b0;
        spi_cs = 1'b1;
        check_eq("t5_newd", 32'(spi_newd), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_gid0", 32'(grant_id), 32'd0);
        acc = '0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acc = acc | ack | err;
            if (busy !== 1'b0) cnt++;
        end
        check_eq("t5_no_ackerr", 32'(acc), 32'd0);
        check_eq("t5_stay_idle", 32'(cnt), 32'd0);
        req = 4'b0101;
        wait_grant(gcyc);
        check_eq("t5_fresh_gid", 32'(grant_id), 32'd0);
        serve(2, 3, 4'b0001, a, e, acyc);
        check_eq("t5_ack0", 32'(a), 32'b0001);
        wait_grant(gcyc);
        check_eq("t5_next_gid", 32'(grant_id), 32'd2);
        serve(2, 3, 4'b0100, a, e, acyc);
        check_eq("t5_ack2", 32'(a), 32'b0100);

        // 6: req dropped during ACTIVE still completes
        req = 4'b0100;
        wait_grant(gcyc);
        check_eq("t6_gid", 32'(grant_id), 32'd2);
        serve(3, 8, 4'b0100, a, e, acyc);
        check_eq("t6_ack", 32'(a), 32'b0100);
        check_eq("t6_err", 32'(e), 32'd0);
        repeat (GAP + 2) @(negedge clk);
        check_eq("t6_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
